// File: rtl/mem_loader_pkg.sv
// Shared definitions for the venus program loader: command codes, FSM states
// and field widths.
package mem_loader_pkg;

    localparam logic [7:0] CMD_IMEM = 8'h01;
    localparam logic [7:0] CMD_DMEM = 8'h02;
    localparam logic [7:0] CMD_RUN  = 8'h03;

    localparam int unsigned BYTE_CNT_W  = 2;
    localparam int unsigned ADDR_FLD_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_ADR_HI,
        ST_ADR_LO,
        ST_DATA,
        ST_RUN
    } state_e;

    typedef enum logic {
        TGT_IMEM,
        TGT_DMEM
    } target_e;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and memory write ports of the loader.
// The loader is the slave; the byte source / memory side is the master.
interface mem_loader_if #(
    parameter int unsigned IADDR_W = 10,
    parameter int unsigned DADDR_W = 10
);
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               imem_we;
    logic [IADDR_W-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready,
        input  imem_we, imem_addr, imem_wdata,
        input  dmem_we, dmem_addr, dmem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready,
        output imem_we, imem_addr, imem_wdata,
        output dmem_we, dmem_addr, dmem_wdata
    );
endinterface

// File: rtl/mem_loader_word_assembler.sv
// Big-endian byte-to-word assembler: collects four bytes, MSB first, and
// flags the byte that completes a word.
module mem_loader_word_assembler
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    // Only three bytes need storing; the fourth is taken straight from byte_in.
    logic [23:0]           shift_q, shift_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (byte_valid) begin
            shift_d = {shift_q[15:0], byte_in};
            cnt_d   = cnt_q + BYTE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word      = {shift_q, byte_in};
    assign word_done = byte_valid && (cnt_q == '1);

endmodule

// File: rtl/mem_loader.sv
// Framed byte-stream loader: writes big-endian words into imem/dmem and holds
// the core in reset until a RUN command is received.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned IADDR_W = 10,
    parameter int unsigned DADDR_W = 10,
    parameter int unsigned CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_loader_if.slave  bus,
    output logic         core_run,
    output logic         busy,
    output logic         err
);

    state_e                state_q, state_d;
    target_e               tgt_q, tgt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            addr_hi_q, addr_hi_d;
    logic [ADDR_FLD_W-1:0] waddr_q, waddr_d;
    logic                  err_q, err_d;
    logic                  imem_we_q, imem_we_d;
    logic [IADDR_W-1:0]    imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  dmem_we_q, dmem_we_d;
    logic [DADDR_W-1:0]    dmem_addr_q, dmem_addr_d;
    logic [31:0]           dmem_wdata_q, dmem_wdata_d;

    logic        in_ready;
    logic        accept;
    logic        data_byte;
    logic [31:0] word;
    logic        word_done;

    assign in_ready  = (state_q != ST_RUN);
    assign accept    = bus.in_valid && in_ready;
    assign data_byte = accept && (state_q == ST_DATA);

    mem_loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (data_byte),
        .byte_in    (bus.in_data),
        .word       (word),
        .word_done  (word_done)
    );

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        cnt_d        = cnt_q;
        addr_hi_d    = addr_hi_q;
        waddr_d      = waddr_q;
        err_d        = err_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_data == CMD_IMEM) begin
                        tgt_d   = TGT_IMEM;
                        state_d = ST_CNT_HI;
                    end else if (bus.in_data == CMD_DMEM) begin
                        tgt_d   = TGT_DMEM;
                        state_d = ST_CNT_HI;
                    end else if (bus.in_data == CMD_RUN) begin
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_CNT_HI: begin
                    cnt_d   = CNT_W'({bus.in_data, 8'h00});
                    state_d = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    cnt_d   = cnt_q | CNT_W'(bus.in_data);
                    state_d = ST_ADR_HI;
                end
                ST_ADR_HI: begin
                    addr_hi_d = bus.in_data;
                    state_d   = ST_ADR_LO;
                end
                ST_ADR_LO: begin
                    waddr_d = {addr_hi_q, bus.in_data};
                    state_d = (cnt_q == '0) ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (word_done) begin
                        if (tgt_q == TGT_IMEM) begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = waddr_q[IADDR_W-1:0];
                            imem_wdata_d = word;
                        end else begin
                            dmem_we_d    = 1'b1;
                            dmem_addr_d  = waddr_q[DADDR_W-1:0];
                            dmem_wdata_d = word;
                        end
                        // Wrap past the port width happens through truncation.
                        waddr_d = waddr_q + ADDR_FLD_W'(1);
                        cnt_d   = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tgt_q        <= TGT_IMEM;
            cnt_q        <= '0;
            addr_hi_q    <= '0;
            waddr_q      <= '0;
            err_q        <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            cnt_q        <= cnt_d;
            addr_hi_q    <= addr_hi_d;
            waddr_q      <= waddr_d;
            err_q        <= err_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;

    assign core_run = (state_q == ST_RUN);
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_RUN);
    assign err      = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a table of bytes with expected outputs one
// cycle after acceptance, plus stall, mid-frame reset and RUN sequences.
module tb_mem_loader;

    logic clk;
    logic rst;
    logic core_run;
    logic busy;
    logic err;

    mem_loader_if #(.IADDR_W(10), .DADDR_W(10)) bus ();

    mem_loader #(.IADDR_W(10), .DADDR_W(10), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .core_run (core_run),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic        iwe;
        logic        dwe;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        bsy;
        logic        er;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Write-strobe monitor, sampled on the falling edge.
    int          iwe_cnt = 0;
    int          dwe_cnt = 0;
    logic [9:0]  last_iaddr = '0;
    logic [31:0] last_idata = '0;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            iwe_cnt    = iwe_cnt + 1;
            last_iaddr = bus.imem_addr;
            last_idata = bus.imem_wdata;
        end
        if (bus.dmem_we) dwe_cnt = dwe_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input logic iwe, input logic dwe,
                       input logic [9:0] addr, input logic [31:0] wdata,
                       input logic bsy, input logic er);
        vec_t v;
        v.b = b; v.iwe = iwe; v.dwe = dwe; v.addr = addr;
        v.wdata = wdata; v.bsy = bsy; v.er = er;
        vt.push_back(v);
    endtask

    // Plain byte, busy expected, no write, err as given.
    task automatic addb(input logic [7:0] b, input logic er);
        add(b, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, er);
    endtask

    // Drive one byte from a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_ctl"},
              {58'h0, bus.in_ready, bus.imem_we, bus.dmem_we, core_run, busy, err},
              {58'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check({name, "_addr"}, {44'h0, bus.imem_addr, bus.dmem_addr}, 64'h0);
        check({name, "_wdata"}, {bus.imem_wdata, bus.dmem_wdata}, 64'h0);
    endtask

    initial begin
        int i0;
        int d0;
        int bad_run;
        logic [9:0]  a_addr;
        logic [31:0] a_data;

        // imem, 2 words at 0x010; next command accepted while last strobe is high
        addb(8'h01, 0); addb(8'h00, 0); addb(8'h02, 0); addb(8'h00, 0); addb(8'h10, 0);
        addb(8'hDE, 0); addb(8'hAD, 0); addb(8'hBE, 0);
        add(8'hEF, 1, 0, 10'h010, 32'hDEADBEEF, 1, 0);
        addb(8'h00, 0); addb(8'h00, 0); addb(8'h00, 0);
        add(8'h13, 1, 0, 10'h011, 32'h00000013, 0, 0);
        // dmem, 1 word at 0x3FF (address truncated from 0x03FF)
        addb(8'h02, 0); addb(8'h00, 0); addb(8'h01, 0); addb(8'h03, 0); addb(8'hFF, 0);
        addb(8'h12, 0); addb(8'h34, 0); addb(8'h56, 0);
        add(8'h78, 0, 1, 10'h3FF, 32'h12345678, 0, 0);
        // dmem, 2 words at 0x3FF: second wraps to 0x000
        addb(8'h02, 0); addb(8'h00, 0); addb(8'h02, 0); addb(8'h03, 0); addb(8'hFF, 0);
        addb(8'hA1, 0); addb(8'hA2, 0); addb(8'hA3, 0);
        add(8'hA4, 0, 1, 10'h3FF, 32'hA1A2A3A4, 1, 0);
        addb(8'hB1, 0); addb(8'hB2, 0); addb(8'hB3, 0);
        add(8'hB4, 0, 1, 10'h000, 32'hB1B2B3B4, 0, 0);
        // zero-length frame returns to idle without error
        addb(8'h01, 0); addb(8'h00, 0); addb(8'h00, 0); addb(8'h00, 0);
        add(8'h05, 0, 0, 10'h000, 32'h0, 0, 0);
        // bad command sets sticky err; the following frame still lands
        add(8'h7F, 0, 0, 10'h000, 32'h0, 0, 1);
        addb(8'h01, 1); addb(8'h00, 1); addb(8'h01, 1); addb(8'h00, 1); addb(8'h20, 1);
        addb(8'h11, 1); addb(8'h22, 1); addb(8'h33, 1);
        add(8'h44, 1, 0, 10'h020, 32'h11223344, 0, 1);

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[k]) begin
            send(vt[k].b);
            a_addr = vt[k].iwe ? bus.imem_addr  : (vt[k].dwe ? bus.dmem_addr  : 10'h000);
            a_data = vt[k].iwe ? bus.imem_wdata : (vt[k].dwe ? bus.dmem_wdata : 32'h0);
            check($sformatf("vec%0d_byte%02h", k, vt[k].b),
                  {18'h0, bus.imem_we, bus.dmem_we, busy, err, a_addr, a_data},
                  {18'h0, vt[k].iwe, vt[k].dwe, vt[k].bsy, vt[k].er, vt[k].addr, vt[k].wdata});
        end

        // Stalled stream: five idle cycles between every byte
        @(negedge clk);
        i0 = iwe_cnt;
        d0 = dwe_cnt;
        send_gap(8'h01); send_gap(8'h00); send_gap(8'h01); send_gap(8'h00); send_gap(8'h30);
        send_gap(8'hCA); send_gap(8'hFE); send_gap(8'hBA); send_gap(8'hBE);
        check("stall_we_count", {32'(iwe_cnt - i0), 32'(dwe_cnt - d0)}, {32'd1, 32'd0});
        check("stall_write", {22'h0, last_iaddr, last_idata}, {22'h0, 10'h030, 32'hCAFEBABE});

        // Reset after two data bytes of a word aborts the frame
        i0 = iwe_cnt;
        send(8'h01); send(8'h00); send(8'h01); send(8'h00); send(8'h40);
        send(8'hAA); send(8'hBB);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_no_write", 64'(iwe_cnt - i0), 64'd0);
        send(8'h01); send(8'h00); send(8'h01); send(8'h00); send(8'h41);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        @(negedge clk);
        check("fresh_we_count", 64'(iwe_cnt - i0), 64'd1);
        check("fresh_write", {22'h0, last_iaddr, last_idata}, {22'h0, 10'h041, 32'h01020304});

        // Zero-length frame, then RUN
        send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h05);
        check("pre_run", {61'h0, core_run, busy, err}, {61'h0, 1'b0, 1'b0, 1'b0});
        i0 = iwe_cnt;
        d0 = dwe_cnt;
        send(8'h03);
        check("run_entry", {61'h0, core_run, bus.in_ready, busy}, {61'h0, 1'b1, 1'b0, 1'b0});
        bad_run = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0 || core_run !== 1'b1 || busy !== 1'b0) bad_run++;
        end
        bus.in_valid = 1'b0;
        check("run_hold_100", 64'(bad_run), 64'd0);
        check("run_no_writes", {32'(iwe_cnt - i0), 32'(dwe_cnt - d0)}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
